// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK valid-padding convolution with NUM_FEATURE_MAPS
// parallel filters. Raster pixels in, one saturated (optionally ReLU'd) vector
// out per window position, with ready/valid backpressure on both sides.
module conv2d_stream #(
   parameter int IMG_W            = 32,
   parameter int IMG_H            = 32,
   parameter int K                = 5,
   parameter int NUM_FEATURE_MAPS = 6,
   parameter int DATA_W           = 8,
   parameter int COEF_W           = 8,
   parameter int OUT_W            = 16,
   parameter int RELU             = 0,
   localparam int NCOEF           = NUM_FEATURE_MAPS * (K * K + 1),
   localparam int CAW             = $clog2(NCOEF)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_feature_valid,
   input  logic [DATA_W-1:0]        i_feature,
   output logic                     o_ready_feature,
   input  logic                     i_coef_we,
   input  logic [CAW-1:0]           i_coef_addr,
   input  logic signed [COEF_W-1:0] i_coef,
   output logic                     o_coef_ready,
   input  logic                     i_out_ready,
   output logic                     o_feature_valid,
   output logic signed [OUT_W-1:0]  o_features [0:NUM_FEATURE_MAPS-1],
   output logic                     o_frame_done
);

   localparam int NM   = NUM_FEATURE_MAPS;
   localparam int KK   = K * K;
   localparam int TPM  = KK + 1;
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);
   localparam int PW   = DATA_W + COEF_W + 1;
   localparam int ACCW = PW + $clog2(KK + 1);

   localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic                     rdy_q;
   logic [CW-1:0]            col_q;
   logic [RW-1:0]            row_q;
   logic                     stall, adv, accept, last_col, last_row, win_ok;

   logic [DATA_W-1:0]        lb_q  [0:K-2][0:IMG_W-1];
   logic [DATA_W-1:0]        win_q [0:K-1][0:K-1];
   logic [DATA_W-1:0]        colv  [0:K-1];
   logic signed [COEF_W-1:0] cf_q  [0:NCOEF-1];

   logic                     v0_q, v1_q, v2_q, v3_q;
   logic                     f0_q, f1_q, f2_q, f3_q;
   logic signed [PW-1:0]     prod_d [0:NM-1][0:KK-1];
   logic signed [PW-1:0]     prod_q [0:NM-1][0:KK-1];
   logic signed [ACCW-1:0]   sum_d  [0:NM-1];
   logic signed [ACCW-1:0]   sum_q  [0:NM-1];
   logic signed [OUT_W-1:0]  out_d  [0:NM-1];
   logic signed [OUT_W-1:0]  out_q  [0:NM-1];

   assign stall           = v3_q && !i_out_ready;
   assign adv             = !stall;
   assign o_ready_feature = rdy_q && !i_rst && !stall;
   assign accept          = i_feature_valid && o_ready_feature;
   assign last_col        = (col_q == CW'(IMG_W - 1));
   assign last_row        = (row_q == RW'(IMG_H - 1));
   assign win_ok          = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
   assign o_coef_ready    = rdy_q && !i_rst && (row_q == '0) && (col_q == '0) &&
                            !(v0_q || v1_q || v2_q || v3_q);

   assign o_feature_valid = v3_q;
   assign o_frame_done    = f3_q;
   assign o_features      = out_q;

   // Raster position counters; ready flag rises the cycle after reset releases
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rdy_q <= 1'b0;
         col_q <= '0;
         row_q <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (accept) begin
            if (last_col) begin
               col_q <= '0;
               row_q <= last_row ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
      end
   end

   // New window column: K-1 buffered rows above the incoming pixel (top first)
   always_comb begin
      colv[K-1] = i_feature;
      for (int unsigned i = 0; i < K - 1; i++) begin
         colv[i] = lb_q[K-2-i][col_q];
      end
   end

   // Line buffers shift down one row at the current column; stale data is gated by win_ok
   always_ff @(posedge i_clk) begin
      if (accept) begin
         lb_q[0][col_q] <= i_feature;
         for (int unsigned r = 1; r < K - 1; r++) begin
            lb_q[r][col_q] <= lb_q[r-1][col_q];
         end
      end
   end

   // Sliding KxK window: shift left and append the new column on the right
   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K - 1; j++) begin
               win_q[i][j] <= win_q[i][j+1];
            end
            win_q[i][K-1] <= colv[i];
         end
      end
   end

   // Coefficient/bias store, writable only while the frame is idle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned a = 0; a < NCOEF; a++) cf_q[a] <= '0;
      end else if (i_coef_we && o_coef_ready) begin
         for (int unsigned a = 0; a < NCOEF; a++) begin
            if (i_coef_addr == CAW'(a)) cf_q[a] <= i_coef;
         end
      end
   end

   // Per-tap signed products (pixel zero-extended to make it non-negative)
   always_comb begin
      for (int unsigned m = 0; m < NM; m++) begin
         for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
               prod_d[m][i*K+j] = PW'(signed'({1'b0, win_q[i][j]})) * PW'(cf_q[m*TPM + i*K + j]);
            end
         end
      end
   end

   // Adder tree plus sign-extended bias in full precision
   always_comb begin
      logic signed [ACCW-1:0] acc;
      for (int unsigned m = 0; m < NM; m++) begin
         acc = ACCW'(cf_q[m*TPM + KK]);
         for (int unsigned t = 0; t < KK; t++) begin
            acc = acc + ACCW'(prod_q[m][t]);
         end
         sum_d[m] = acc;
      end
   end

   // Saturate to OUT_W, then optional ReLU
   always_comb begin
      for (int unsigned m = 0; m < NM; m++) begin
         if (sum_q[m] > SAT_MAX) begin
            out_d[m] = {1'b0, {(OUT_W-1){1'b1}}};
         end else if (sum_q[m] < SAT_MIN) begin
            out_d[m] = {1'b1, {(OUT_W-1){1'b0}}};
         end else begin
            out_d[m] = sum_q[m][OUT_W-1:0];
         end
         if (RELU != 0 && out_d[m] < 0) out_d[m] = '0;
      end
   end

   // Window-valid flag then three datapath stages; everything freezes on stall
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         {v0_q, v1_q, v2_q, v3_q} <= '0;
         {f0_q, f1_q, f2_q, f3_q} <= '0;
         prod_q <= '{default: '0};
         sum_q  <= '{default: '0};
         out_q  <= '{default: '0};
      end else if (adv) begin
         v0_q   <= accept && win_ok;
         f0_q   <= accept && last_row && last_col;
         v1_q   <= v0_q;
         f1_q   <= f0_q;
         prod_q <= prod_d;
         v2_q   <= v1_q;
         f2_q   <= f1_q;
         sum_q  <= sum_d;
         v3_q   <= v2_q;
         f3_q   <= f2_q;
         out_q  <= out_d;
      end
   end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream: table of constant-pixel frames,
// scoreboard fed by a frame-image reference model, plus stall, coefficient
// gating, mid-frame reset and a small RELU=1 instance.
module tb_conv2d_stream;

   localparam int W = 32, H = 32, K = 5, NM = 6, KK = K * K, TPM = KK + 1;
   localparam int NCOEF = NM * TPM;
   localparam int NWIN = (W - K + 1) * (H - K + 1);

   logic clk, rst;
   logic fv = 1'b0;
   logic [7:0] fpix = '0;
   logic rdy_f, crdy, ovalid, fdone;
   logic cwe = 1'b0;
   logic [7:0] caddr = '0;
   logic signed [7:0] cdat = '0;
   logic ordy = 1'b1;
   logic signed [15:0] feat [0:NM-1];

   logic fv2 = 1'b0, cwe2 = 1'b0, ordy2 = 1'b1;
   logic [7:0] fpix2 = '0;
   logic [4:0] caddr2 = '0;
   logic signed [7:0] cdat2 = '0;
   logic rdy2, crdy2, ov2, fd2;
   logic signed [15:0] feat2 [0:1];

   conv2d_stream #(.IMG_W(W), .IMG_H(H), .K(K), .NUM_FEATURE_MAPS(NM), .DATA_W(8),
                   .COEF_W(8), .OUT_W(16), .RELU(0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_feature_valid(fv), .i_feature(fpix),
      .o_ready_feature(rdy_f), .i_coef_we(cwe), .i_coef_addr(caddr), .i_coef(cdat),
      .o_coef_ready(crdy), .i_out_ready(ordy), .o_feature_valid(ovalid),
      .o_features(feat), .o_frame_done(fdone));

   conv2d_stream #(.IMG_W(3), .IMG_H(3), .K(3), .NUM_FEATURE_MAPS(2), .DATA_W(8),
                   .COEF_W(8), .OUT_W(16), .RELU(1)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_feature_valid(fv2), .i_feature(fpix2),
      .o_ready_feature(rdy2), .i_coef_we(cwe2), .i_coef_addr(caddr2), .i_coef(cdat2),
      .o_coef_ready(crdy2), .i_out_ready(ordy2), .o_feature_valid(ov2),
      .o_features(feat2), .o_frame_done(fd2));

   typedef struct {
      int f [0:NM-1];
      bit fd;
   } exp_t;

   typedef struct {
      int pix; int c0; int b0; int c1; int b1; int e0; int e1;
   } vec_t;

   exp_t sbq [$];
   int   mcoef [0:NCOEF-1];
   int   img [0:H-1][0:W-1];
   int   total = 0, bad = 0;
   int   cyc = 0, b_row = 0, b_col = 0, n_out = 0, const_pix = 0;
   int   acc44_cyc = -1, first_out_cyc = -1, first0 = 0, first1 = 0, last0 = 0;
   int   rdy_mode = 0;
   bit   prev_stall = 0;
   logic signed [15:0] held [0:NM-1];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int model_out(input int m, input int r, input int c);
      longint acc = mcoef[m*TPM + KK];
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            acc += longint'(img[r-K+1+i][c-K+1+j]) * mcoef[m*TPM + i*K + j];
      if (acc > 32767) return 32767;
      if (acc < -32768) return -32768;
      return int'(acc);
   endfunction

   function automatic int pix(input int mode, input int r, input int c);
      case (mode)
         0: return const_pix;
         1: return c;
         default: return (r * 7 + c * 13 + r * c) & 255;
      endcase
   endfunction

   // downstream ready pattern: 0 = always, 1 = random 50%, 2 = held low
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: ordy = 1'b1;
            1: ordy = 1'($urandom_range(0, 1));
            default: ordy = 1'b0;
         endcase
      end
   end

   // output monitor / scoreboard consumer, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid_hold", ovalid, 1);
               for (int m = 0; m < NM; m++) chk($sformatf("stall_hold%0d", m), feat[m], held[m]);
            end
            prev_stall = ovalid && !ordy;
            if (prev_stall) begin
               chk("stall_no_accept", rdy_f, 0);
               held = feat;
            end
            if (!ovalid) chk("fdone_idle", fdone, 0);
            if (ovalid && first_out_cyc < 0) first_out_cyc = cyc;
            if (ovalid && ordy) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  for (int m = 0; m < NM; m++) chk($sformatf("feat%0d", m), feat[m], e.f[m]);
                  chk("frame_done", fdone, e.fd);
                  if (n_out == 0) begin
                     first0 = feat[0];
                     first1 = feat[1];
                  end
                  last0 = feat[0];
                  n_out++;
               end
            end
         end
      end
   end

   task automatic send_pix(input int p);
      bit ok = 0;
      exp_t e;
      fv = 1'b1;
      fpix = 8'(p);
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (rdy_f) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      img[b_row][b_col] = p;
      if (b_row == 4 && b_col == 4 && acc44_cyc < 0) acc44_cyc = cyc + 1;
      if (b_row >= K - 1 && b_col >= K - 1) begin
         for (int m = 0; m < NM; m++) e.f[m] = model_out(m, b_row, b_col);
         e.fd = (b_row == H - 1 && b_col == W - 1);
         sbq.push_back(e);
      end
      if (b_col == W - 1) begin
         b_col = 0;
         b_row = (b_row == H - 1) ? 0 : b_row + 1;
      end else begin
         b_col++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int mode, input int npix);
      int n = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (n < npix) begin
               send_pix(pix(mode, r, c));
               n++;
            end
      fv = 1'b0;
   endtask

   task automatic end_frame(input int nexp);
      for (int n = 0; n < 400 && sbq.size() != 0; n++) @(posedge clk);
      chk("drain", sbq.size(), 0);
      chk("out_count", n_out, nexp);
      n_out = 0;
      #1;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (crdy) break;
      end
      chk("coef_ready_idle", crdy, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int v, input bit taken);
      cwe = 1'b1;
      caddr = 8'(a);
      cdat = 8'(v);
      @(negedge clk);
      chk("coef_ready", crdy, taken);
      if (taken) mcoef[a] = v;
      @(posedge clk);
      #1;
      cwe = 1'b0;
   endtask

   task automatic load_map(input int m, input int tap, input int bias);
      for (int t = 0; t < KK; t++) wr(m*TPM + t, tap, 1);
      wr(m*TPM + KK, bias, 1);
   endtask

   initial begin
      vec_t tbl [5];
      int c0;
      tbl[0] = '{pix: 40,  c0: 1,   b0: 0,   c1: -1,   b1: 5,    e0: 1000,  e1: -995};
      tbl[1] = '{pix: 255, c0: 127, b0: 0,   c1: -128, b1: 0,    e0: 32767, e1: -32768};
      tbl[2] = '{pix: 0,   c0: 127, b0: -7,  c1: -128, b1: 100,  e0: -7,    e1: 100};
      tbl[3] = '{pix: 10,  c0: -3,  b0: 127, c1: 50,   b1: -128, e0: -623,  e1: 12372};
      tbl[4] = '{pix: 200, c0: 6,   b0: -1,  c1: -7,   b1: 0,    e0: 29999, e1: -32768};
      for (int a = 0; a < NCOEF; a++) mcoef[a] = 0;

      // reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", rdy_f, 0);
      chk("rst_valid", ovalid, 0);
      chk("rst_fdone", fdone, 0);
      chk("rst_coef_ready", crdy, 0);
      for (int m = 0; m < NM; m++) chk($sformatf("rst_feat%0d", m), feat[m], 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_rst", rdy_f, 1);
      chk("coef_ready_after_rst", crdy, 1);
      @(posedge clk);
      #1;

      // constant-pixel table
      for (int v = 0; v < 5; v++) begin
         wait_idle();
         load_map(0, tbl[v].c0, tbl[v].b0);
         load_map(1, tbl[v].c1, tbl[v].b1);
         const_pix = tbl[v].pix;
         c0 = cyc;
         send_frame(0, W * H);
         if (v == 0) chk("throughput", cyc - c0, W * H);
         end_frame(NWIN);
         chk($sformatf("tbl%0d_map0", v), first0, tbl[v].e0);
         chk($sformatf("tbl%0d_map1", v), first1, tbl[v].e1);
         if (v == 0) chk("latency", first_out_cyc - acc44_cyc, 3);
      end

      // ramp, two frames back to back across the wrap
      wait_idle();
      load_map(0, 0, 0);
      wr(12, 1, 1);
      c0 = cyc;
      send_frame(1, W * H);
      send_frame(1, W * H);
      chk("wrap_no_bubble", cyc - c0, 2 * W * H);
      end_frame(2 * NWIN);
      chk("ramp_first", first0, 2);
      chk("ramp_last", last0, 29);

      // backpressure: random ready plus a 10-cycle hold mid-frame
      wait_idle();
      rdy_mode = 1;
      fork
         send_frame(2, W * H);
         begin
            repeat (700) @(posedge clk);
            rdy_mode = 2;
            repeat (10) @(posedge clk);
            rdy_mode = 1;
         end
      join
      end_frame(NWIN);
      rdy_mode = 0;

      // coefficient write during a frame is ignored, after the frame it applies
      wait_idle();
      load_map(0, 1, 0);
      fork
         send_frame(2, W * H);
         begin
            repeat (300) @(posedge clk);
            #1 wr(0, 77, 0);
         end
      join
      end_frame(NWIN);
      wait_idle();
      wr(0, 77, 1);
      send_frame(2, W * H);
      end_frame(NWIN);

      // reset after pixel 500
      wait_idle();
      send_frame(2, 500);
      rst = 1'b1;
      sbq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", ovalid, 0);
      chk("midrst_ready", rdy_f, 0);
      chk("midrst_coef_ready", crdy, 0);
      for (int m = 0; m < NM; m++) chk($sformatf("midrst_feat%0d", m), feat[m], 0);
      for (int a = 0; a < NCOEF; a++) mcoef[a] = 0;
      b_row = 0;
      b_col = 0;
      n_out = 0;
      @(posedge clk);
      #1;
      wait_idle();
      const_pix = 123;
      send_frame(0, W * H);
      end_frame(NWIN);
      chk("zero_coef_out", last0, 0);
      wait_idle();
      load_map(0, 1, 0);
      load_map(1, -1, 5);
      load_map(2, 3, -20);
      send_frame(2, W * H);
      end_frame(NWIN);

      // RELU=1 instance: 3x3 image, 3x3 kernel, single window
      chk("relu_coef_ready", crdy2, 1);
      for (int a = 0; a < 20; a++) begin
         cwe2 = 1'b1;
         caddr2 = 5'(a);
         cdat2 = (a < 9) ? 8'sd127 : (a == 9) ? 8'sd0 : -8'sd128;
         @(posedge clk);
         #1;
      end
      cwe2 = 1'b0;
      fpix2 = 8'd255;
      fv2 = 1'b1;
      for (int n = 0; n < 9; n++) begin
         @(negedge clk);
         if (n == 0) chk("relu_ready", rdy2, 1);
         @(posedge clk);
         #1;
      end
      fv2 = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (ov2) break;
      end
      chk("relu_valid", ov2, 1);
      chk("relu_map0_sat", feat2[0], 32767);
      chk("relu_map1_clamp", feat2[1], 0);
      chk("relu_frame_done", fd2, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
